// File: rtl/countdown_timer_core_pkg.sv
// Shared types and constants for the MM:SS countdown timer core.
// Build option: define ALARM_BLINK_EN to make the alarm output flash at the tick rate.
package countdown_timer_core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam int SEC_MAX = 59;
  localparam int BCD_W   = 8;

endpackage

// File: rtl/countdown_timer_core_if.sv
// Control and display bundle between the timer core and the board-level logic.
interface countdown_timer_core_if;
  import countdown_timer_core_pkg::*;

  logic             tick_in;
  logic             load;
  logic [6:0]       load_min;
  logic [5:0]       load_sec;
  logic             start;
  logic             stop;
  logic [BCD_W-1:0] min_bcd;
  logic [BCD_W-1:0] sec_bcd;
  logic             running;
  logic             alarm;
  logic             done;

  modport master (
    output tick_in, load, load_min, load_sec, start, stop,
    input  min_bcd, sec_bcd, running, alarm, done
  );

  modport slave (
    input  tick_in, load, load_min, load_sec, start, stop,
    output min_bcd, sec_bcd, running, alarm, done
  );

endinterface

// File: rtl/countdown_timer_core_bin2bcd_99.sv
// Combinational binary (0..99) to two-digit BCD converter: tens in [7:4], units in [3:0].
module bin2bcd_99
  import countdown_timer_core_pkg::*;
(
  input  logic [6:0]       bin,
  output logic [BCD_W-1:0] bcd
);

  logic [3:0] tens;
  logic [3:0] units;

  // Tens digit is the number of multiples of ten the value reaches.
  always_comb begin
    tens = 4'd0;
    for (int i = 1; i <= 9; i++) begin
      if (bin >= 7'(i * 10)) begin
        tens = 4'(i);
      end
    end
    units = 4'(bin - 7'd10 * {3'b000, tens});
  end

  assign bcd = {tens, units};

endmodule

// File: rtl/countdown_timer_core.sv
// MM:SS countdown timer: recovers tick enables from the divided clock and runs the control FSM.
// Build option: ALARM_BLINK_EN makes alarm toggle on each tick while in ALARM.
module countdown_timer_core
  import countdown_timer_core_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 99
) (
  input logic                    clk,
  input logic                    reset,
  countdown_timer_core_if.slave  bus
);

  localparam logic [6:0] MAX_MIN_L = 7'(MAX_MIN);
  localparam logic [5:0] SEC_MAX_L = 6'(SEC_MAX);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  state_t                 state_q, state_d;
  logic [6:0]             min_q, min_d;
  logic [5:0]             sec_q, sec_d;
  logic                   done_q, done_d;
  logic                   tick_pulse;
  logic [6:0]             load_min_c;
  logic [5:0]             load_sec_c;

  // Synchroniser plus rising-edge detect turns the slow square wave into one-cycle ticks.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], bus.tick_in};
    prev_d     = sync_q[SYNC_STAGES-1];
    tick_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
    load_min_c = (bus.load_min > MAX_MIN_L) ? MAX_MIN_L : bus.load_min;
    load_sec_c = (bus.load_sec > SEC_MAX_L) ? SEC_MAX_L : bus.load_sec;
  end

  // Event priority is load, then stop, then start, then tick.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    done_d  = 1'b0;
    if (bus.load) begin
      min_d   = load_min_c;
      sec_d   = load_sec_c;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.stop && bus.start && (min_q != 7'd0 || sec_q != 6'd0)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_d = PAUSE;
          end else if (tick_pulse) begin
            if (sec_q != 6'd0) begin
              sec_d = sec_q - 6'd1;
            end else if (min_q != 7'd0) begin
              sec_d = SEC_MAX_L;
              min_d = min_q - 7'd1;
            end
            if (min_q == 7'd0 && sec_q == 6'd1) begin
              state_d = ALARM;
              done_d  = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (!bus.stop && bus.start) begin
            state_d = RUN;
          end
        end
        ALARM: begin
          if (bus.stop) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      min_q   <= 7'd0;
      sec_q   <= 6'd0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      done_q  <= done_d;
    end
  end

`ifdef ALARM_BLINK_EN
  logic blink_q, blink_d;

  // Blink starts lit on entry to ALARM and is dark whenever the FSM is elsewhere.
  always_comb begin
    blink_d = 1'b0;
    if (state_d == ALARM) begin
      if (state_q != ALARM) begin
        blink_d = 1'b1;
      end else if (tick_pulse) begin
        blink_d = ~blink_q;
      end else begin
        blink_d = blink_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign bus.alarm = blink_q;
`else
  assign bus.alarm = (state_q == ALARM);
`endif

  assign bus.running = (state_q == RUN);
  assign bus.done    = done_q;

  bin2bcd_99 u_min_bcd (
    .bin (min_q),
    .bcd (bus.min_bcd)
  );

  bin2bcd_99 u_sec_bcd (
    .bin ({1'b0, sec_q}),
    .bcd (bus.sec_bcd)
  );

endmodule

// File: tb/tb_countdown_timer_core.sv
// Directed self-checking bench for countdown_timer_core (default SYNC_STAGES=2, MAX_MIN=99).
// Blink-specific checks are compiled in when ALARM_BLINK_EN is defined.
module tb_countdown_timer_core;

  logic clk;
  logic reset;
  int   check_count;
  int   pass_count;
  int   done_count;

  countdown_timer_core_if bus_if ();

  countdown_timer_core #(
    .SYNC_STAGES (2),
    .MAX_MIN     (99)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // done is a one-cycle pulse, so count it once per cycle away from the active edge
  always @(negedge clk) begin
    if (bus_if.done === 1'b1) done_count++;
  end

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    check_count++;
    assert (observed === expected) begin
      pass_count++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_load(input logic [6:0] m, input logic [5:0] s);
    bus_if.load_min = m;
    bus_if.load_sec = s;
    bus_if.load     = 1'b1;
    cycles(1);
    bus_if.load     = 1'b0;
  endtask

  task automatic apply_start();
    bus_if.start = 1'b1;
    cycles(1);
    bus_if.start = 1'b0;
  endtask

  task automatic apply_stop();
    bus_if.stop = 1'b1;
    cycles(1);
    bus_if.stop = 1'b0;
  endtask

  task automatic apply_tick();
    bus_if.tick_in = 1'b1;
    cycles(4);
    bus_if.tick_in = 1'b0;
    cycles(4);
  endtask

  logic [7:0] exp_min [5] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
  logic [7:0] exp_sec [5] = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h59};

  initial begin
    check_count     = 0;
    pass_count      = 0;
    done_count      = 0;
    reset           = 1'b1;
    bus_if.tick_in  = 1'b0;
    bus_if.load     = 1'b0;
    bus_if.load_min = 7'd0;
    bus_if.load_sec = 6'd0;
    bus_if.start    = 1'b0;
    bus_if.stop     = 1'b0;

    // Reset state, with the divided clock toggling across release
    cycles(2);
    bus_if.tick_in = 1'b1;
    cycles(2);
    reset = 1'b0;
    bus_if.tick_in = 1'b0;
    cycles(2);
    apply_tick();
    check_output("reset_min", bus_if.min_bcd, 8'h00);
    check_output("reset_sec", bus_if.sec_bcd, 8'h00);
    check_output("reset_running", {7'd0, bus_if.running}, 8'h00);
    check_output("reset_alarm", {7'd0, bus_if.alarm}, 8'h00);
    check_output("reset_done_count", 8'(done_count), 8'h00);

    // Load 1:05 and count six ticks, checking the three-cycle tick latency
    apply_load(7'd1, 6'd5);
    check_output("load105_min", bus_if.min_bcd, 8'h01);
    check_output("load105_sec", bus_if.sec_bcd, 8'h05);
    apply_start();
    check_output("run_running", {7'd0, bus_if.running}, 8'h01);
    bus_if.tick_in = 1'b1;
    cycles(2);
    check_output("latency_before", bus_if.sec_bcd, 8'h05);
    cycles(1);
    check_output("latency_after", bus_if.sec_bcd, 8'h04);
    cycles(1);
    bus_if.tick_in = 1'b0;
    cycles(4);
    for (int i = 0; i < 5; i++) begin
      apply_tick();
      check_output($sformatf("seq_min_%0d", i), bus_if.min_bcd, exp_min[i]);
      check_output($sformatf("seq_sec_%0d", i), bus_if.sec_bcd, exp_sec[i]);
    end

    // Expiry from 0:02: one done pulse, alarm held, display parked at 00:00
    apply_load(7'd0, 6'd2);
    apply_start();
    done_count = 0;
    apply_tick();
    check_output("exp_sec_01", bus_if.sec_bcd, 8'h01);
    bus_if.tick_in = 1'b1;
    cycles(3);
    check_output("exp_done_pulse", {7'd0, bus_if.done}, 8'h01);
    cycles(1);
    check_output("exp_done_low", {7'd0, bus_if.done}, 8'h00);
    bus_if.tick_in = 1'b0;
    cycles(4);
    check_output("exp_done_count", 8'(done_count), 8'h01);
    check_output("exp_alarm", {7'd0, bus_if.alarm}, 8'h01);
    check_output("exp_running", {7'd0, bus_if.running}, 8'h00);
    check_output("exp_sec_00", bus_if.sec_bcd, 8'h00);
    apply_tick();
`ifdef ALARM_BLINK_EN
    check_output("blink_1", {7'd0, bus_if.alarm}, 8'h00);
`else
    check_output("alarm_steady_1", {7'd0, bus_if.alarm}, 8'h01);
`endif
    apply_tick();
`ifdef ALARM_BLINK_EN
    check_output("blink_2", {7'd0, bus_if.alarm}, 8'h01);
`else
    check_output("alarm_steady_2", {7'd0, bus_if.alarm}, 8'h01);
`endif
    check_output("alarm_hold_min", bus_if.min_bcd, 8'h00);
    check_output("alarm_hold_sec", bus_if.sec_bcd, 8'h00);
    check_output("alarm_done_count", 8'(done_count), 8'h01);
    apply_start();
    check_output("alarm_start_ignored", {7'd0, bus_if.running}, 8'h00);
    apply_stop();
    check_output("stop_alarm_clear", {7'd0, bus_if.alarm}, 8'h00);
    apply_start();
    check_output("idle_start_at_zero", {7'd0, bus_if.running}, 8'h00);

    // Pause holds the count through ticks, resume continues
    apply_load(7'd0, 6'd10);
    apply_start();
    repeat (3) apply_tick();
    check_output("pause_pre_sec", bus_if.sec_bcd, 8'h07);
    apply_stop();
    check_output("pause_running", {7'd0, bus_if.running}, 8'h00);
    repeat (5) apply_tick();
    check_output("pause_hold_sec", bus_if.sec_bcd, 8'h07);
    apply_start();
    check_output("resume_running", {7'd0, bus_if.running}, 8'h01);
    apply_tick();
    check_output("resume_sec", bus_if.sec_bcd, 8'h06);

    // Clamping of out-of-range loads
    apply_load(7'd120, 6'd63);
    check_output("clamp_min", bus_if.min_bcd, 8'h99);
    check_output("clamp_sec", bus_if.sec_bcd, 8'h59);
    apply_load(7'd0, 6'd0);
    apply_start();
    check_output("zero_start_running", {7'd0, bus_if.running}, 8'h00);

    // Load landing in the same cycle as a tick pulse wins with no decrement
    apply_load(7'd0, 6'd40);
    apply_start();
    bus_if.tick_in  = 1'b1;
    cycles(2);
    bus_if.load_min = 7'd0;
    bus_if.load_sec = 6'd30;
    bus_if.load     = 1'b1;
    cycles(1);
    bus_if.load     = 1'b0;
    check_output("load_tick_sec", bus_if.sec_bcd, 8'h30);
    check_output("load_tick_running", {7'd0, bus_if.running}, 8'h00);
    cycles(1);
    bus_if.tick_in = 1'b0;
    cycles(4);
    apply_tick();
    check_output("idle_tick_hold", bus_if.sec_bcd, 8'h30);

    // Asynchronous reset in RUN clears immediately without a done pulse
    apply_load(7'd2, 6'd15);
    apply_start();
    done_count = 0;
    #2 reset = 1'b1;
    #1;
    check_output("async_rst_min", bus_if.min_bcd, 8'h00);
    check_output("async_rst_running", {7'd0, bus_if.running}, 8'h00);
    cycles(2);
    reset = 1'b0;
    cycles(2);
    check_output("async_rst_done", 8'(done_count), 8'h00);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
